// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Op codes, bus constants, FSM states and the memory-op decoder.
package mem_lsu_pkg;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic       sext;
        logic [1:0] size;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [7:0] op);
        mem_op_t d;
        d = '0;
        unique case (1'b1)
            (op == EXE_LB_OP):  d = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
            (op == EXE_LH_OP):  d = '{1'b1, 1'b1, 1'b1, SZ_HALF};
            (op == EXE_LW_OP):  d = '{1'b1, 1'b1, 1'b0, SZ_WORD};
            (op == EXE_LBU_OP): d = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
            (op == EXE_LHU_OP): d = '{1'b1, 1'b1, 1'b0, SZ_HALF};
            (op == EXE_SB_OP):  d = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
            (op == EXE_SH_OP):  d = '{1'b1, 1'b0, 1'b0, SZ_HALF};
            (op == EXE_SW_OP):  d = '{1'b1, 1'b0, 1'b0, SZ_WORD};
            default:            d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the LSU: lane enables, store replication,
// load extraction/extension and alignment check.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [7:0]  aluop,
    input  logic [1:0]  offset,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic        is_mem,
    output logic        is_load,
    output logic        misalign,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    mem_op_t     op;
    logic [1:0]  lane;
    logic        hi_half;
    logic [7:0]  b;
    logic [15:0] h;

    assign op      = decode_op(aluop);
    assign is_mem  = op.valid;
    assign is_load = op.is_load;

    always_comb begin
        lane      = BIG_ENDIAN ? 2'd3 - offset : offset;
        hi_half   = BIG_ENDIAN ? ~offset[1] : offset[1];
        b         = rdata[{lane, 3'b000} +: 8];
        h         = hi_half ? rdata[31:16] : rdata[15:0];
        misalign  = 1'b0;
        sel       = 4'b0000;
        wdata     = ZeroWord;
        rdata_ext = ZeroWord;
        if (op.valid) begin
            case (op.size)
                SZ_BYTE: begin
                    sel       = 4'b0001 << lane;
                    wdata     = {4{reg2[7:0]}};
                    rdata_ext = {{24{op.sext & b[7]}}, b};
                end
                SZ_HALF: begin
                    misalign  = offset[0];
                    sel       = hi_half ? 4'b1100 : 4'b0011;
                    wdata     = {2{reg2[15:0]}};
                    rdata_ext = {{16{op.sext & h[15]}}, h};
                end
                default: begin
                    misalign  = |offset;
                    sel       = 4'b1111;
                    wdata     = reg2;
                    rdata_ext = rdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: pass-through for ALU ops, one req/ack bus transaction
// per load/store with pipeline stall and bus timeout.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_wdata,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        excpt_misalign,
    output logic        excpt_buserr
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    lsu_state_e  state, nstate;
    logic [CW-1:0] cnt;
    logic        err;
    logic [31:0] ldata;
    logic        is_mem, is_load, misalign, valid, timeout;
    logic [3:0]  sel;
    logic [31:0] st_data, ld_ext;

    lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .aluop     (mem_aluop),
        .offset    (mem_addr[1:0]),
        .reg2      (mem_reg2),
        .rdata     (bus_rdata),
        .is_mem    (is_mem),
        .is_load   (is_load),
        .misalign  (misalign),
        .sel       (sel),
        .wdata     (st_data),
        .rdata_ext (ld_ext)
    );

    assign valid   = is_mem & ~misalign;
    assign timeout = (state == S_REQ) & ~bus_ack & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  if (valid) nstate = bus_ack ? S_DONE : S_REQ;
            S_REQ:   if (bus_ack || timeout) nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Counter, error flag and captured load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            err   <= 1'b0;
            ldata <= ZeroWord;
        end else if (state == S_REQ) begin
            if (bus_ack) begin
                ldata <= ld_ext;
            end else if (timeout) begin
                err   <= 1'b1;
                ldata <= ZeroWord;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
            err <= 1'b0;
            if (state == S_IDLE && valid && bus_ack) ldata <= ld_ext;
        end
    end

    always_comb begin
        wb_wdata       = mem_wdata;
        wb_wd          = mem_wd;
        wb_wreg        = mem_wreg;
        stallreq       = 1'b0;
        bus_req        = 1'b0;
        bus_we         = 1'b0;
        bus_addr       = ZeroWord;
        bus_sel        = 4'b0000;
        bus_wdata      = ZeroWord;
        excpt_misalign = 1'b0;
        excpt_buserr   = 1'b0;
        if (!rst) begin
            wb_wdata = ZeroWord;
            wb_wd    = NOPRegAddr;
            wb_wreg  = 1'b0;
        end else if (misalign) begin
            wb_wreg        = 1'b0;
            excpt_misalign = 1'b1;
        end else if (is_mem) begin
            if (state == S_DONE) begin
                wb_wdata     = is_load ? ldata : mem_wdata;
                wb_wreg      = is_load & ~err & mem_wreg;
                excpt_buserr = err;
            end else begin
                wb_wreg   = 1'b0;
                stallreq  = 1'b1;
                bus_req   = 1'b1;
                bus_we    = ~is_load;
                bus_addr  = {mem_addr[31:2], 2'b00};
                bus_sel   = sel;
                bus_wdata = st_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed and randomized accesses
// against a lane-arithmetic reference model.
module tb_mem_lsu;

    localparam int TO = 16;
    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_wdata, mem_addr, mem_reg2, bus_rdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg, bus_ack;
    logic [7:0]  mem_aluop;
    logic [31:0] wb_wdata, bus_addr, bus_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg, stallreq, bus_req, bus_we;
    logic [3:0]  bus_sel;
    logic        excpt_misalign, excpt_buserr;

    int checks = 0;
    int failures = 0;

    mem_lsu #(.TIMEOUT(TO), .BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst(rst),
        .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
        .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .excpt_misalign(excpt_misalign), .excpt_buserr(excpt_buserr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: sizes in bytes, lane = lowest byte lane touched
    function automatic void model(input logic [7:0] op, input logic [31:0] addr,
                                  input logic [31:0] reg2, input logic [31:0] rdata,
                                  output bit mis, output bit ld, output logic [3:0] sel,
                                  output logic [31:0] wd, output logic [31:0] ext);
        int size, k, lane;
        bit sgn;
        logic [31:0] mask, raw;
        case (op)
            8'hE0: begin size = 1; ld = 1; sgn = 1; end
            8'hE1: begin size = 2; ld = 1; sgn = 1; end
            8'hE3: begin size = 4; ld = 1; sgn = 0; end
            8'hE4: begin size = 1; ld = 1; sgn = 0; end
            8'hE5: begin size = 2; ld = 1; sgn = 0; end
            8'hE8: begin size = 1; ld = 0; sgn = 0; end
            8'hE9: begin size = 2; ld = 0; sgn = 0; end
            default: begin size = 4; ld = 0; sgn = 0; end
        endcase
        k    = int'(addr % 4);
        mis  = (k % size) != 0;
        lane = BE ? (4 - size - k) : k;
        sel  = 4'(((1 << size) - 1) << lane);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        raw  = (rdata >> (8 * lane)) & mask;
        ext  = (sgn && raw[8 * size - 1]) ? (raw | ~mask) : raw;
        if (size == 1)      wd = (reg2 & 32'hFF) * 32'h0101_0101;
        else if (size == 2) wd = (reg2 & 32'hFFFF) * 32'h0001_0001;
        else                wd = reg2;
    endfunction

    task automatic idle_inputs();
        mem_aluop = 8'h00; mem_wreg = 1'b0; mem_wd = 5'd0;
        mem_wdata = 32'd0; mem_addr = 32'd0; mem_reg2 = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
    endtask

    // n = stall-cycle index in which ack is raised (0 = first cycle)
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] reg2, input logic [31:0] rdata,
                             input int n, input logic wreg);
        bit mis, ld, tout;
        logic [3:0] esel;
        logic [31:0] ewd, eext, wdat, exp_wb;
        logic [4:0] wd;
        logic exp_wreg;
        int nstall;
        wd   = 5'($urandom_range(1, 31));
        wdat = $urandom;
        model(op, addr, reg2, rdata, mis, ld, esel, ewd, eext);
        @(posedge clk); #1;
        mem_aluop = op; mem_addr = addr; mem_reg2 = reg2;
        mem_wdata = wdat; mem_wd = wd; mem_wreg = wreg;
        bus_rdata = rdata; bus_ack = (n == 0);
        #3;
        if (mis) begin
            checks++;
            if (excpt_misalign !== 1'b1 || bus_req !== 1'b0 || stallreq !== 1'b0 || wb_wreg !== 1'b0) begin
                failures++;
                $display("FAIL misalign op=%h addr=%h: mis=%b req=%b stall=%b wreg=%b, want 1 0 0 0",
                         op, addr, excpt_misalign, bus_req, stallreq, wb_wreg);
            end
        end else begin
            tout   = n > TO - 1;
            nstall = tout ? TO : n + 1;
            checks++;
            if (bus_sel !== esel || bus_we !== !ld || (!ld && bus_wdata !== ewd) ||
                bus_addr !== {addr[31:2], 2'b00}) begin
                failures++;
                $display("FAIL bus_fields op=%h addr=%h: sel=%b we=%b wdata=%h baddr=%h, want %b %b %h %h",
                         op, addr, bus_sel, bus_we, bus_wdata, bus_addr, esel, !ld, ewd, {addr[31:2], 2'b00});
            end
            for (int c = 0; c < nstall; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                    bus_ack = (c == n);
                    #3;
                end
                checks++;
                if (stallreq !== 1'b1 || bus_req !== 1'b1 || bus_sel !== esel) begin
                    failures++;
                    $display("FAIL stall op=%h cycle=%0d: stall=%b req=%b sel=%b, want 1 1 %b",
                             op, c, stallreq, bus_req, bus_sel, esel);
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'($urandom_range(0, 1));
            #3;
            exp_wb   = ld ? (tout ? 32'd0 : eext) : wdat;
            exp_wreg = ld && !tout && wreg;
            checks++;
            if (stallreq !== 1'b0 || bus_req !== 1'b0 || wb_wdata !== exp_wb ||
                wb_wreg !== exp_wreg || excpt_buserr !== tout || wb_wd !== wd) begin
                failures++;
                $display("FAIL done op=%h addr=%h: stall=%b req=%b wdata=%h wreg=%b berr=%b wd=%0d, want 0 0 %h %b %b %0d",
                         op, addr, stallreq, bus_req, wb_wdata, wb_wreg, excpt_buserr, wb_wd,
                         exp_wb, exp_wreg, tout, wd);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        mem_aluop = 8'hE3; mem_addr = 32'h40; mem_wreg = 1'b1;
        mem_wd = 5'd7; mem_wdata = 32'hDEAD_BEEF;
        #12;
        checks++;
        if (wb_wdata !== 32'd0 || wb_wd !== 5'd0 || wb_wreg !== 1'b0 || stallreq !== 1'b0 ||
            bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'd0 || bus_sel !== 4'd0 ||
            bus_wdata !== 32'd0 || excpt_misalign !== 1'b0 || excpt_buserr !== 1'b0) begin
            failures++;
            $display("FAIL reset: wdata=%h wd=%0d wreg=%b stall=%b req=%b sel=%b, want all zero",
                     wb_wdata, wb_wd, wb_wreg, stallreq, bus_req, bus_sel);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [7:0] op;
        logic [7:0] odd_ops [6];
        odd_ops = '{8'hE2, 8'hE6, 8'hE7, 8'hEA, 8'hEC, 8'hFF};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                op = 8'h20; mem_wdata = 32'h1234; mem_wd = 5'd5; mem_wreg = 1'b1;
            end else begin
                op = (i % 3 == 0) ? odd_ops[$urandom_range(0, 5)] : 8'($urandom_range(0, 8'hDF));
                mem_wdata = $urandom; mem_wd = 5'($urandom); mem_wreg = 1'($urandom);
            end
            mem_aluop = op; mem_addr = $urandom; mem_reg2 = $urandom;
            bus_ack = 1'($urandom_range(0, 1));
            #3;
            checks++;
            if (wb_wdata !== mem_wdata || wb_wd !== mem_wd || wb_wreg !== mem_wreg ||
                stallreq !== 1'b0 || bus_req !== 1'b0 || excpt_misalign !== 1'b0) begin
                failures++;
                $display("FAIL passthrough op=%h: wdata=%h wd=%0d wreg=%b stall=%b req=%b, want %h %0d %b 0 0",
                         op, wb_wdata, wb_wd, wb_wreg, stallreq, bus_req, mem_wdata, mem_wd, mem_wreg);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_directed();
        do_access(8'hE0, 32'h101, 32'h0, 32'h1180_2233, 3, 1'b1);
        do_access(8'hE5, 32'h202, 32'h0, 32'hAAAA_8001, 1, 1'b1);
        do_access(8'hE8, 32'h3, 32'h0000_00AB, 32'h0, 2, 1'b1);
        do_access(8'hE3, 32'h6, 32'h0, 32'h0, 1, 1'b1);
        do_access(8'hE1, 32'h10, 32'h0, 32'h8123_4567, 0, 1'b1);
        do_access(8'hEB, 32'h24, 32'hCAFE_F00D, 32'h0, TO - 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_access(8'hE3, 32'h80, 32'h0, 32'h5555_AAAA, 1000, 1'b1);
        do_access(8'hE9, 32'h82, 32'h0000_BEEF, 32'h0, 1000, 1'b0);
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        mem_aluop = 8'hE3; mem_addr = 32'h40; mem_wreg = 1'b1; mem_wd = 5'd9;
        bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || stallreq !== 1'b0 || wb_wd !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_req: req=%b stall=%b wd=%0d, want 0 0 0", bus_req, stallreq, wb_wd);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        do_access(8'hE3, 32'h44, 32'h0, 32'h0BAD_F00D, 1, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] ops [8];
        logic [31:0] addr;
        int n;
        ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
        for (int i = 0; i < 30; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
            n = (i % 10 == 9) ? 100 : $urandom_range(0, 5);
            do_access(ops[$urandom_range(0, 7)], addr, $urandom, $urandom, n, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_timeout();
        test_reset_mid_req();
        test_random();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Non-memory ops pass through the stage.
- Loads and stores run one data-bus transaction using a req/ack handshake. The pipeline is stalled until the transaction completes, or until it times out.
- Does lane select, store data replication, load sign/zero extension, misalignment detection and bus timeout.

Parameters:
- TIMEOUT, 16: cycles to wait for bus_ack before abandoning the access. Must be ≥2.
- BIG_ENDIAN, 1: 1 means address offset 0 maps to byte lane 3; 0 means offset 0 maps to lane 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mem_wdata  in  32  ALU result / non-load write data
- mem_wd  in  5  destination register address
- mem_wreg  in  1  register write enable
- mem_aluop  in  8  operation code
- mem_addr  in  32  effective address
- mem_reg2  in  32  store source data
- wb_wdata  out  32  data to MEM/WB
- wb_wd  out  5  destination to MEM/WB
- wb_wreg  out  1  write enable to MEM/WB
- stallreq  out  1  stall request to pipeline control
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address; bits [1:0] forced to 00
- bus_sel  out  4  byte lane enables
- bus_wdata  out  32  store data
- bus_rdata  in  32  load data
- bus_ack  in  1  transaction complete, one-cycle pulse
- excpt_misalign  out  1  misaligned access flag
- excpt_buserr  out  1  bus timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE; timeout counter and load-data register are cleared.
  - All outputs are 0 while reset is held: wb_wd=NOPRegAddr, bus_* inactive, stallreq=0.
- Memory op codes are LB E0, LH E1, LW E3, LBU E4, LHU E5, SB E8, SH E9, SW EB. Every other code is a non-memory op.
- Non-memory op: wb_* = mem_* combinationally; stallreq=0; no bus activity.
- Misaligned access:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - Response in the same cycle, combinationally: no bus access, wb_wreg=0, excpt_misalign=1, stallreq=0.
- FSM states are IDLE, REQ and DONE.
- IDLE with a valid memory op:
  - bus_req=1 and stallreq=1, both combinational.
  - Next state is REQ unless bus_ack is already 1, in which case it is DONE.
- REQ:
  - bus_req=1 and stallreq=1.
  - All bus_* outputs stay stable until bus_ack.
  - On bus_ack: latch the extended load data and go to DONE.
  - The counter increments each REQ cycle. When it reaches TIMEOUT-1 without an ack: go to DONE with the error flag set and load data 0.
- DONE (one cycle):
  - stallreq=0; wb_wdata = latched load data for loads, mem_wdata for stores.
  - wb_wreg=mem_wreg for loads and 0 for stores, or 0 on error. excpt_buserr=1 if the access timed out.
  - Next state is IDLE; the counter clears.
- Load latency is at least 2 cycles after the op arrives at the EX/MEM outputs (IDLE→REQ/DONE).
- Lanes with BIG_ENDIAN=1:
  - Byte op, offset k: sel = 1000 >> k.
  - Half op: sel = 1100 at offset 0, 0011 at offset 2.
  - Word op: sel = 1111.
- Store data: bytes are replicated ×4, halves are replicated ×2.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- The upstream register holds mem_* stable while stallreq=1; the stage is not required to behave correctly if mem_* changes mid-transaction.
- A bus_ack seen in IDLE or DONE is ignored.
- Reset during REQ aborts the access immediately; bus_req drops asynchronously.

Decomposition:
- The op codes, AluOpBus, RegBus, RegAddrBus, ZeroWord and NOPRegAddr constants go in the shared Defines.v.
- One sub-module, lsu_align, is natural: purely combinational, producing sel, store replication, load extraction/extension and the misalign flag.
- The FSM and counter stay in mem_lsu.

Test Plan:
- ADD pass-through: mem_wdata=0x1234, wd=5, wreg=1 → wb_wdata=0x1234 and wb_wd=5 in the same cycle; stallreq=0; bus_req=0.
- LB, addr=0x101, bus_rdata=0x11802233, ack after 3 cycles:
  - bus_sel=0100, bus_addr=0x100, stallreq=1 for 4 cycles.
  - DONE shows wb_wdata=0xFFFFFF80.
- LHU, addr=0x202, rdata=0xAAAA8001 → sel=0011, wb_wdata=0x00008001.
- SB, addr=0x3, reg2=0x000000AB → bus_we=1, sel=0001, bus_wdata=0xABABABAB; DONE has wb_wreg=0.
- LW, addr=0x6 → excpt_misalign=1, bus_req=0, wb_wreg=0, stallreq=0.
- LW with no ack, TIMEOUT=16 → stallreq held 16 cycles; DONE shows excpt_buserr=1, wb_wreg=0. A separate run with rst pulled low mid-REQ shows bus_req=0 immediately.
